// File: rtl/syn_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : syn_sram_arb_if
// Description : Requester-side bundle for the shared SRAM arbiter. The flat
//               per-requester vectors are sliced by requester index i:
//               addr_id[18i+17:18i], be_id[2i+1:2i], wdata_id[16i+15:16i].
// Ports       : req_ih/wr_ih/addr_id/be_id/wdata_id  requester -> arbiter
//               ack_oh/rd_valid_oh/rd_data_od        arbiter -> requester
//               modport master = requester side, modport slave = arbiter side
// Revision    : 1.0  initial release
// ============================================================================
interface syn_sram_arb_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_ih;
    logic [NUM_REQ-1:0]    wr_ih;
    logic [NUM_REQ*18-1:0] addr_id;
    logic [NUM_REQ*2-1:0]  be_id;
    logic [NUM_REQ*16-1:0] wdata_id;
    logic [NUM_REQ-1:0]    ack_oh;
    logic [NUM_REQ-1:0]    rd_valid_oh;
    logic [15:0]           rd_data_od;

    modport master (
        output req_ih, wr_ih, addr_id, be_id, wdata_id,
        input  ack_oh, rd_valid_oh, rd_data_od
    );

    modport slave (
        input  req_ih, wr_ih, addr_id, be_id, wdata_id,
        output ack_oh, rd_valid_oh, rd_data_od
    );
endinterface
`default_nettype wire

// File: rtl/syn_sram_arb.sv
`default_nettype none
// ============================================================================
// Module      : syn_sram_arb
// Description : Round-robin arbiter sharing one 256K x 16 asynchronous SRAM
//               between NUM_REQ requesters. Each access runs a fixed number of
//               read or write cycles; every SRAM pin is driven from a flop.
// Ports       : clk_ir        system clock, rising edge
//               rst_il        synchronous reset, active low
//               bus           requester bundle (syn_sram_arb_if.slave)
//               sram_dq       bidirectional SRAM data bus
//               sram_addr_od  SRAM word address
//               sram_*_ol     SRAM strobes (lb, ub, ce, oe, we), active low
// Revision    : 1.0  initial release
// ============================================================================
module syn_sram_arb #(
    parameter int NUM_REQ   = 3,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  wire          clk_ir,
    input  wire          rst_il,
    syn_sram_arb_if.slave bus,
    inout  wire  [15:0]  sram_dq,
    output logic [17:0]  sram_addr_od,
    output logic         sram_lb_ol,
    output logic         sram_ub_ol,
    output logic         sram_ce_ol,
    output logic         sram_oe_ol,
    output logic         sram_we_ol
);
    localparam int c_IDX_W   = $clog2(NUM_REQ);
    localparam int c_MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_RD_LOAD  = c_CNT_W'(RD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD  = c_CNT_W'(WR_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD     = 2'd1,
        S_WR     = 2'd2,
        S_WR_REL = 2'd3
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [c_IDX_W-1:0]  r_last,     w_last_nxt;
    logic [c_IDX_W-1:0]  r_grant,    w_grant_nxt;
    logic [15:0]         r_wdata,    w_wdata_nxt;
    logic [17:0]         r_addr,     w_addr_nxt;
    logic [15:0]         r_rd_data,  w_rd_data_nxt;
    logic                r_lb,       w_lb_nxt;
    logic                r_ub,       w_ub_nxt;
    logic                r_ce,       w_ce_nxt;
    logic                r_oe,       w_oe_nxt;
    logic                r_we,       w_we_nxt;
    logic                r_dq_oe,    w_dq_oe_nxt;
    logic [NUM_REQ-1:0]  r_ack,      w_ack_nxt;
    logic [NUM_REQ-1:0]  r_rd_pend,  w_rd_pend_nxt;
    logic [NUM_REQ-1:0]  r_rd_valid;

    // Arbitration results
    logic [NUM_REQ-1:0]  w_req_eff;
    logic                w_any;
    logic [c_IDX_W-1:0]  w_win;
    logic                w_win_wr;
    logic [17:0]         w_win_addr;
    logic [1:0]          w_win_be;
    logic [15:0]         w_win_wdata;
    int                  w_best;
    int                  w_dist;

    // A requester whose read data is about to be flagged next cycle is held
    // off for that one cycle, so its ack can never coincide with its rd_valid.
    // Winner = set bit with the smallest distance after last grant.
    always_comb begin
        w_req_eff   = bus.req_ih & ~r_rd_pend;
        w_any       = |w_req_eff;
        w_win       = r_last;
        w_win_wr    = 1'b0;
        w_win_addr  = '0;
        w_win_be    = '0;
        w_win_wdata = '0;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
            if (w_req_eff[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_win       = c_IDX_W'(i);
                w_win_wr    = bus.wr_ih[i];
                w_win_addr  = bus.addr_id[i*18 +: 18];
                w_win_be    = bus.be_id[i*2 +: 2];
                w_win_wdata = bus.wdata_id[i*16 +: 16];
            end
        end
    end

    // Next-state and next-output logic. Output flops take the values of the
    // state being entered, so strobes change on the same edge as the state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_grant_nxt   = r_grant;
        w_wdata_nxt   = r_wdata;
        w_addr_nxt    = r_addr;
        w_rd_data_nxt = r_rd_data;
        w_lb_nxt      = r_lb;
        w_ub_nxt      = r_ub;
        w_ce_nxt      = r_ce;
        w_oe_nxt      = r_oe;
        w_we_nxt      = r_we;
        w_dq_oe_nxt   = r_dq_oe;
        w_ack_nxt     = '0;
        w_rd_pend_nxt = '0;

        case (r_state)
            S_IDLE: begin
                w_lb_nxt    = 1'b1;
                w_ub_nxt    = 1'b1;
                w_ce_nxt    = 1'b1;
                w_oe_nxt    = 1'b1;
                w_we_nxt    = 1'b1;
                w_dq_oe_nxt = 1'b0;
                if (w_any) begin
                    w_ack_nxt   = c_ONE << w_win;
                    w_grant_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_wdata_nxt = w_win_wdata;
                    w_addr_nxt  = w_win_addr;
                    w_lb_nxt    = ~w_win_be[0];
                    w_ub_nxt    = ~w_win_be[1];
                    w_ce_nxt    = 1'b0;
                    if (w_win_wr) begin
                        w_state_nxt = S_WR;
                        w_cnt_nxt   = c_WR_LOAD;
                        w_we_nxt    = 1'b0;
                        w_dq_oe_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RD;
                        w_cnt_nxt   = c_RD_LOAD;
                        w_oe_nxt    = 1'b0;
                    end
                end
            end

            S_RD: begin
                if (r_cnt == '0) begin
                    w_rd_data_nxt = sram_dq;
                    w_rd_pend_nxt = c_ONE << r_grant;
                    w_lb_nxt      = 1'b1;
                    w_ub_nxt      = 1'b1;
                    w_ce_nxt      = 1'b1;
                    w_oe_nxt      = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end

            S_WR: begin
                if (r_cnt == '0) begin
                    // Address and data stay put for one more cycle (hold time)
                    w_we_nxt    = 1'b1;
                    w_ce_nxt    = 1'b1;
                    w_lb_nxt    = 1'b1;
                    w_ub_nxt    = 1'b1;
                    w_state_nxt = S_WR_REL;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end

            S_WR_REL: begin
                w_dq_oe_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_lb_nxt    = 1'b1;
                w_ub_nxt    = 1'b1;
                w_ce_nxt    = 1'b1;
                w_oe_nxt    = 1'b1;
                w_we_nxt    = 1'b1;
                w_dq_oe_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= c_LAST_RST;
            r_grant    <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_rd_data  <= '0;
            r_lb       <= 1'b1;
            r_ub       <= 1'b1;
            r_ce       <= 1'b1;
            r_oe       <= 1'b1;
            r_we       <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_ack      <= '0;
            r_rd_pend  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_grant    <= w_grant_nxt;
            r_wdata    <= w_wdata_nxt;
            r_addr     <= w_addr_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_lb       <= w_lb_nxt;
            r_ub       <= w_ub_nxt;
            r_ce       <= w_ce_nxt;
            r_oe       <= w_oe_nxt;
            r_we       <= w_we_nxt;
            r_dq_oe    <= w_dq_oe_nxt;
            r_ack      <= w_ack_nxt;
            r_rd_pend  <= w_rd_pend_nxt;
            // Data is captured one edge earlier; the flag follows a cycle later
            r_rd_valid <= r_rd_pend;
        end
    end

    assign sram_dq         = r_dq_oe ? r_wdata : 16'hzzzz;
    assign sram_addr_od    = r_addr;
    assign sram_lb_ol      = r_lb;
    assign sram_ub_ol      = r_ub;
    assign sram_ce_ol      = r_ce;
    assign sram_oe_ol      = r_oe;
    assign sram_we_ol      = r_we;
    assign bus.ack_oh      = r_ack;
    assign bus.rd_valid_oh = r_rd_valid;
    assign bus.rd_data_od  = r_rd_data;
endmodule
`default_nettype wire
